// File: rtl/alu_mul_seq_pkg.sv
// alu_mul_seq_pkg: shared states, ALU function codes and iteration count for the multiply sequencer
package alu_mul_seq_pkg;
  typedef enum logic [2:0] {IDLE, NEGA, NEGB, ITER, NEGLO, NEGHI, DONE} state_t;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam int N_ITER = 32;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative 32x32->64 MULT/MULTU sequencer that borrows the shared ALU for every add/negate
module alu_mul_seq
  import alu_mul_seq_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] alu_r,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  output logic        alu_own,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_t      r_state, w_next;
  logic [31:0] r_mcand, r_hi, r_lo;
  logic [4:0]  r_cnt;
  logic        r_sign, r_neg, r_lo_zero;
  logic        w_carry;
  assign w_carry = alu_r < r_hi;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? NEGA : IDLE;
      NEGA:    w_next = NEGB;
      NEGB:    w_next = ITER;
      ITER:    w_next = (r_cnt == 5'(N_ITER - 1)) ? NEGLO : ITER;
      NEGLO:   w_next = NEGHI;
      NEGHI:   w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    alu_own  = r_state inside {NEGA, NEGB, ITER, NEGLO, NEGHI};
    alu_aluc = !alu_own ? 4'd0 : (r_state == ITER) ? ALU_ADD : ALU_SUB;
    alu_a    = (r_state == ITER) ? r_hi :
               (r_state == NEGHI) ? (r_lo_zero ? 32'd0 : 32'hFFFF_FFFF) : 32'd0;
    alu_b    = (r_state == NEGA) ? r_mcand :
               (r_state == NEGB || r_state == NEGLO) ? r_lo :
               (r_state == ITER) ? (r_lo[0] ? r_mcand : 32'd0) :
               (r_state == NEGHI) ? r_hi : 32'd0;
    busy     = r_state != IDLE;
    done     = r_state == DONE;
    hi       = r_hi;
    lo       = r_lo;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_neg     <= 1'b0;
      r_lo_zero <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (start) begin
          r_mcand <= op_a;
          r_lo    <= op_b;
          r_hi    <= '0;
          r_sign  <= sign;
          r_neg   <= sign & (op_a[31] ^ op_b[31]);
          r_cnt   <= '0;
        end
        NEGA: if (r_sign & r_mcand[31]) r_mcand <= alu_r;
        NEGB: if (r_sign & r_lo[31]) r_lo <= alu_r;
        ITER: begin
          {r_hi, r_lo} <= {w_carry, alu_r, r_lo[31:1]};
          r_cnt        <= r_cnt + 5'd1;
        end
        NEGLO: begin
          r_lo_zero <= r_lo == '0;
          if (r_neg) r_lo <= alu_r;
        end
        NEGHI: if (r_neg) r_hi <= alu_r;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed MULT/MULTU vectors against a behavioural shared ALU
module tb_alu_mul_seq;
  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, sign = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, alu_r, alu_a, alu_b, hi, lo;
  logic [3:0]  alu_aluc;
  logic        alu_own, busy, done;
  int          checks = 0, errors = 0;
  always #5 clock = ~clock;
  assign alu_r = (alu_aluc == 4'b0100) ? alu_a - alu_b : alu_a + alu_b;
  alu_mul_seq dut (
    .clock(clock), .reset(reset), .start(start), .sign(sign),
    .op_a(op_a), .op_b(op_b), .alu_r(alu_r),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_own(alu_own),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input int rk);
    int busy_n = 0, own_n = 0, own_first = 0, own_last = 0, done_n = 0, done_at = 0;
    logic [63:0] prod = '0;
    @(negedge clock);
    start = 1'b1; sign = s; op_a = a; op_b = b;
    for (int k = 1; k <= 37; k++) begin
      @(negedge clock);
      busy_n += int'(busy);
      own_n  += int'(alu_own);
      if (alu_own && own_first == 0) own_first = k;
      if (alu_own) own_last = k;
      if (done) begin
        done_n++;
        done_at = k;
        prod = {hi, lo};
      end
      start = (k == rk);
      if (k == rk) begin
        op_a = 32'd100;
        op_b = 32'd100;
      end
    end
    start = 1'b0;
    chk({tag, "_done_at"}, 64'(done_at), 64'd37);
    chk({tag, "_done_n"}, 64'(done_n), 64'd1);
    chk({tag, "_busy_n"}, 64'(busy_n), 64'd37);
    chk({tag, "_own_span"}, {32'(own_first), 32'(own_last)}, {32'd1, 32'd36});
    chk({tag, "_own_n"}, 64'(own_n), 64'd36);
    chk({tag, "_prod"}, prod, exp);
    @(negedge clock);
    chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    chk({tag, "_hold"}, {hi, lo}, exp);
  endtask
  initial begin
    int dn;
    repeat (2) @(negedge clock);
    chk("reset_ctl", {busy, done, alu_own, alu_aluc}, 64'd0);
    chk("reset_alu", {alu_a, alu_b}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    run("u3x5", 1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 0);
    run("uffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    run("sm3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0);
    run("sm7xm6", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 64'h0000_0000_0000_002A, 0);
    run("smin2", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
    run("s0xm1", 1'b1, 32'd0, 32'hFFFF_FFFF, 64'd0, 0);
    run("restart", 1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 5);
    @(negedge clock);
    start = 1'b1; sign = 1'b0; op_a = 32'd7; op_b = 32'd9;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    chk("abort_ctl", {61'd0, busy, done, alu_own}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      dn += int'(done);
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    run("u2x2", 1'b0, 32'd2, 32'd2, 64'd4, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
